// File: rtl/acc_pkg.sv
// Shared types and constants for the tree accumulator.
//   acc_state_e : group-tracking FSM states (no open group / group open)
//   FifoDepth   : number of result entries buffered at the output
//   Def*        : default parameter values for tree_accumulator
package acc_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } acc_state_e;

  localparam int unsigned FifoDepth    = 2;

  localparam int unsigned DefInWidth   = 38;
  localparam int unsigned DefTreeDelay = 5;
  localparam int unsigned DefAccWidth  = 48;
  localparam int unsigned DefOutWidth  = 32;

endpackage

// File: rtl/acc_out_fifo.sv
// Small output FIFO holding finished group sums and their saturation flags.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i,
//   wr_sat_i                 : write request; accepted when not full or when a
//                              pop happens in the same cycle
//   rd_valid_o, rd_ready_i   : valid/ready read handshake
//   rd_data_o, rd_sat_o      : head entry, stable until popped
//   full_o, empty_o          : occupancy status
module acc_out_fifo
  import acc_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 wr_sat_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 rd_sat_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  logic [FifoDepth-1:0][DataWidth-1:0] data_q, data_d;
  logic [FifoDepth-1:0]                sat_q, sat_d;
  logic [PtrW-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]                     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;

  logic do_pop, do_write;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(FifoDepth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CntW'(FifoDepth));
  assign rd_valid_o = !empty_o;
  assign rd_data_o  = data_q[rd_ptr_q];
  assign rd_sat_o   = sat_q[rd_ptr_q];

  assign do_pop   = rd_valid_o && rd_ready_i;
  // When full, the slot being written is the head being popped this cycle.
  assign do_write = wr_en_i && (!full_o || do_pop);

  always_comb begin
    data_d   = data_q;
    sat_d    = sat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_write) begin
      data_d[wr_ptr_q] = wr_data_i;
      sat_d[wr_ptr_q]  = wr_sat_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_write && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_write && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      sat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      sat_q    <= sat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/tree_accumulator.sv
// Accumulates adder-tree results over multi-beat groups and emits one sum per
// group through a 2-entry output FIFO.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, in_last     : beat presented to the tree / final beat of group
//   tree_result           : tree output, TREE_DELAY cycles after its beat
//   out_valid, out_ready  : output handshake
//   out_data, out_sat     : group sum and saturation flag
//   overrun, clr_overrun  : sticky "sum dropped on full FIFO" flag and clear
// Build option: define ACC_SATURATE_EN to clamp sums to the OUT_WIDTH signed
// range (out_sat marks clamped words); otherwise sums wrap and out_sat is 0.
module tree_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = DefInWidth,
  parameter int unsigned TREE_DELAY = DefTreeDelay,
  parameter int unsigned ACC_WIDTH  = DefAccWidth,
  parameter int unsigned OUT_WIDTH  = DefOutWidth
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic signed [IN_WIDTH-1:0]  tree_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic                        overrun,
  input  logic                        clr_overrun
);

  // Beat qualifiers delayed to line up with tree_result.
  logic [TREE_DELAY-1:0] vld_sr_q, vld_sr_d;
  logic [TREE_DELAY-1:0] lst_sr_q, lst_sr_d;
  logic                  d_valid, d_last;

  acc_state_e                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] tree_ext, sum;
  logic                        overrun_q, overrun_d;

  logic                 push;
  logic [OUT_WIDTH-1:0] push_data;
  logic                 push_sat;
  logic                 fifo_full, fifo_empty;
  logic [OUT_WIDTH-1:0] fifo_data;
  logic                 drop;

  always_comb begin
    vld_sr_d = (vld_sr_q << 1) | TREE_DELAY'(in_valid);
    lst_sr_d = (lst_sr_q << 1) | TREE_DELAY'(in_last);
  end

  assign d_valid = vld_sr_q[TREE_DELAY-1];
  assign d_last  = lst_sr_q[TREE_DELAY-1];

  assign tree_ext = ACC_WIDTH'(tree_result);
  // IDLE starts from zero, so this covers both first beat and continuation.
  assign sum      = ((state_q == StAccum) ? acc_q : '0) + tree_ext;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    push    = 1'b0;
    if (d_valid) begin
      if (d_last) begin
        push    = 1'b1;
        state_d = StIdle;
      end else begin
        acc_d   = sum;
        state_d = StAccum;
      end
    end
  end

`ifdef ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SatMax =
      {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
      {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  always_comb begin
    push_data = sum[OUT_WIDTH-1:0];
    push_sat  = 1'b0;
    if (sum > SatMax) begin
      push_data = SatMax[OUT_WIDTH-1:0];
      push_sat  = 1'b1;
    end else if (sum < SatMin) begin
      push_data = SatMin[OUT_WIDTH-1:0];
      push_sat  = 1'b1;
    end
  end
`else
  always_comb begin
    push_data = sum[OUT_WIDTH-1:0];
    push_sat  = 1'b0;
  end
`endif

  assign drop = push && fifo_full && !(out_valid && out_ready);

  always_comb begin
    overrun_d = overrun_q;
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    // A drop in the same cycle as a clear must still be reported.
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q  <= '0;
      lst_sr_q  <= '0;
      state_q   <= StIdle;
      acc_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      vld_sr_q  <= vld_sr_d;
      lst_sr_q  <= lst_sr_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      overrun_q <= overrun_d;
    end
  end

  acc_out_fifo #(
    .DataWidth (OUT_WIDTH)
  ) u_out_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_en_i    (push),
    .wr_data_i  (push_data),
    .wr_sat_i   (push_sat),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (fifo_data),
    .rd_sat_o   (out_sat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign out_data = $signed(fifo_data);
  assign overrun  = overrun_q;

  logic unused_empty;
  assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_tree_accumulator.sv
module tb_tree_accumulator;

  localparam int unsigned TreeDelay = 5;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_last;
  logic signed [37:0] tree_result;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               out_sat;
  logic               overrun;
  logic               clr_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [37:0] pipe [TreeDelay+1];
  logic signed [31:0] got_data [$];
  logic               got_sat  [$];

  tree_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .tree_result (tree_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word that is popped by the handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_sat.push_back(out_sat);
    end
  end

  task automatic check_eq(input string tag, input logic signed [63:0] act,
                          input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Present one beat; the modelled tree returns its value TreeDelay cycles later.
  task automatic step(input logic v, input logic l, input logic signed [63:0] val);
    in_valid = v;
    in_last  = l;
    for (int i = TreeDelay; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0]     = 38'(val);
    tree_result = pipe[TreeDelay];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'sd0);
  endtask

  int n;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    tree_result = '0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    for (int i = 0; i <= TreeDelay; i++) pipe[i] = '0;
    idle(2);
    check_eq("rst_out_valid", 64'(out_valid), 64'sd0);
    check_eq("rst_out_data", out_data, 64'sd0);
    check_eq("rst_out_sat", 64'(out_sat), 64'sd0);
    check_eq("rst_overrun", 64'(overrun), 64'sd0);
    rst_n = 1'b1;
    idle(2);

    // Single-beat group and its latency.
    out_ready = 1'b1;
    got_data.delete(); got_sat.delete();
    step(1'b1, 1'b1, -64'sd7);
    n = 1;
    while (!out_valid && n < 20) begin
      step(1'b0, 1'b0, 64'sd0);
      n++;
    end
    check_eq("single_latency", n, 64'sd6);
    check_eq("single_data_live", out_data, -64'sd7);
    idle(3);
    check_eq("single_count", got_data.size(), 64'sd1);
    if (got_data.size() > 0) check_eq("single_data", got_data[0], -64'sd7);

    // Four-beat group.
    got_data.delete(); got_sat.delete();
    step(1'b1, 1'b0, 64'sd10);
    step(1'b1, 1'b0, 64'sd20);
    step(1'b1, 1'b0, -64'sd5);
    step(1'b1, 1'b1, 64'sd100);
    idle(4);
    check_eq("four_no_early", got_data.size(), 64'sd0);
    check_eq("four_no_early_valid", 64'(out_valid), 64'sd0);
    idle(4);
    check_eq("four_count", got_data.size(), 64'sd1);
    if (got_data.size() > 0) check_eq("four_data", got_data[0], 64'sd125);

    // Back-pressure: third single-beat group is dropped.
    got_data.delete(); got_sat.delete();
    out_ready = 1'b0;
    step(1'b1, 1'b1, 64'sd1);
    step(1'b1, 1'b1, 64'sd2);
    step(1'b1, 1'b1, 64'sd3);
    idle(10);
    check_eq("bp_overrun", 64'(overrun), 64'sd1);
    check_eq("bp_head", out_data, 64'sd1);
    check_eq("bp_none_popped", got_data.size(), 64'sd0);
    out_ready = 1'b1;
    idle(4);
    check_eq("bp_count", got_data.size(), 64'sd2);
    if (got_data.size() > 1) begin
      check_eq("bp_first", got_data[0], 64'sd1);
      check_eq("bp_second", got_data[1], 64'sd2);
    end
    check_eq("bp_drained", 64'(out_valid), 64'sd0);
    check_eq("bp_overrun_sticky", 64'(overrun), 64'sd1);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    check_eq("bp_overrun_clr", 64'(overrun), 64'sd0);

    // Full FIFO with push and pop in the same cycle.
    got_data.delete(); got_sat.delete();
    out_ready = 1'b0;
    step(1'b1, 1'b1, 64'sd4);
    step(1'b1, 1'b1, 64'sd5);
    idle(8);
    step(1'b1, 1'b1, 64'sd6);
    idle(4);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check_eq("pp_overrun", 64'(overrun), 64'sd0);
    check_eq("pp_one_popped", got_data.size(), 64'sd1);
    check_eq("pp_head", out_data, 64'sd5);
    out_ready = 1'b1;
    idle(4);
    check_eq("pp_count", got_data.size(), 64'sd3);
    if (got_data.size() > 2) begin
      check_eq("pp_0", got_data[0], 64'sd4);
      check_eq("pp_1", got_data[1], 64'sd5);
      check_eq("pp_2", got_data[2], 64'sd6);
    end

    // Out-of-range sums: 2^33 and -2^33.
    got_data.delete(); got_sat.delete();
    step(1'b1, 1'b0, 64'sd4294967296);
    step(1'b1, 1'b1, 64'sd4294967296);
    step(1'b1, 1'b0, -64'sd4294967296);
    step(1'b1, 1'b1, -64'sd4294967296);
    idle(10);
    check_eq("sat_count", got_data.size(), 64'sd2);
    if (got_data.size() > 1) begin
`ifdef ACC_SATURATE_EN
      check_eq("sat_pos_data", got_data[0], 64'sd2147483647);
      check_eq("sat_pos_flag", 64'(got_sat[0]), 64'sd1);
      check_eq("sat_neg_data", got_data[1], -64'sd2147483648);
      check_eq("sat_neg_flag", 64'(got_sat[1]), 64'sd1);
`else
      check_eq("wrap_pos_data", got_data[0], 64'sd0);
      check_eq("wrap_pos_flag", 64'(got_sat[0]), 64'sd0);
      check_eq("wrap_neg_data", got_data[1], 64'sd0);
      check_eq("wrap_neg_flag", 64'(got_sat[1]), 64'sd0);
`endif
    end

    // Reset mid-group discards the partial group.
    got_data.delete(); got_sat.delete();
    step(1'b1, 1'b0, 64'sd50);
    step(1'b1, 1'b0, 64'sd60);
    rst_n = 1'b0;
    idle(1);
    check_eq("mid_rst_valid", 64'(out_valid), 64'sd0);
    rst_n = 1'b1;
    idle(10);
    check_eq("mid_rst_no_out", got_data.size(), 64'sd0);
    step(1'b1, 1'b1, 64'sd9);
    idle(8);
    check_eq("mid_rst_count", got_data.size(), 64'sd1);
    if (got_data.size() > 0) check_eq("mid_rst_data", got_data[0], 64'sd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
